pipe_de_regs: RTL

PIPE_DE_REGS -- requirements
Module: pipe_de_regs

---
 rtl/pipe_de_regs.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/pipe_de_regs.sv
// ============================================================================
//  Module   : pipe_de_regs
//  Purpose  : IF/ID and ID/EX pipeline registers with stall, flush and branch
//             clear handling; optional stall/bubble performance counters
//             compiled in with macro PIPE_PERF_CNT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_de_regs #(
    parameter int DW = 32,
    parameter int CW = 16
) (
    input  logic          CLK,
    input  logic          RSTn,
    input  logic          stall,
    input  logic          flush,
    input  logic          clrD,
    input  logic [DW-1:0] instrF,
    input  logic [DW-1:0] pcplus4F,
    input  logic [7:0]    ctrlD,
    input  logic [DW-1:0] rd1D,
    input  logic [DW-1:0] rd2D,
    input  logic [DW-1:0] simmD,
    input  logic [4:0]    rsD,
    input  logic [4:0]    rtD,
    input  logic [4:0]    rdD,
    output logic          pcEnF,
    output logic [DW-1:0] instrD,
    output logic [DW-1:0] pcplus4D,
    output logic          validD,
    output logic [7:0]    ctrlE,
    output logic [DW-1:0] rd1E,
    output logic [DW-1:0] rd2E,
    output logic [DW-1:0] simmE,
    output logic [4:0]    rsE,
    output logic [4:0]    rtE,
    output logic [4:0]    rdE,
    output logic          validE,
    output logic [CW-1:0] stallCnt,
    output logic [CW-1:0] bubbleCnt
);

    logic [DW-1:0] r_instrD;
    logic [DW-1:0] r_pcplus4D;
    logic          r_validD;
    logic [7:0]    r_ctrlE;
    logic [DW-1:0] r_rd1E;
    logic [DW-1:0] r_rd2E;
    logic [DW-1:0] r_simmE;
    logic [4:0]    r_rsE;
    logic [4:0]    r_rtE;
    logic [4:0]    r_rdE;
    logic          r_validE;
    logic          w_bubble_e;

    assign pcEnF      = ~stall;
    assign w_bubble_e = stall | flush;

    // Stall outranks the branch clear so a held instruction is never lost.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_instrD   <= '0;
            r_pcplus4D <= '0;
            r_validD   <= 1'b0;
        end else if (!stall) begin
            if (clrD) begin
                r_instrD   <= '0;
                r_pcplus4D <= '0;
                r_validD   <= 1'b0;
            end else begin
                r_instrD   <= instrF;
                r_pcplus4D <= pcplus4F;
                r_validD   <= 1'b1;
            end
        end
    end

    // Bubbles zero the register specifiers too, keeping forwarding from matching.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn || w_bubble_e) begin
            r_ctrlE  <= '0;
            r_rd1E   <= '0;
            r_rd2E   <= '0;
            r_simmE  <= '0;
            r_rsE    <= '0;
            r_rtE    <= '0;
            r_rdE    <= '0;
            r_validE <= 1'b0;
        end else begin
            r_ctrlE  <= ctrlD;
            r_rd1E   <= rd1D;
            r_rd2E   <= rd2D;
            r_simmE  <= simmD;
            r_rsE    <= rsD;
            r_rtE    <= rtD;
            r_rdE    <= rdD;
            r_validE <= r_validD;
        end
    end

`ifdef PIPE_PERF_CNT_EN
    logic [CW-1:0] r_stall_cnt;
    logic [CW-1:0] r_bubble_cnt;
    logic          w_bubble_evt;

    // A flush always counts; a stall only counts when it displaces a live instruction.
    assign w_bubble_evt = flush | (stall & r_validD);

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (stall && (r_stall_cnt != {CW{1'b1}}))
                r_stall_cnt <= r_stall_cnt + 1'b1;
            if (w_bubble_evt && (r_bubble_cnt != {CW{1'b1}}))
                r_bubble_cnt <= r_bubble_cnt + 1'b1;
        end
    end

    assign stallCnt  = r_stall_cnt;
    assign bubbleCnt = r_bubble_cnt;
`else
    assign stallCnt  = '0;
    assign bubbleCnt = '0;
`endif

    assign instrD   = r_instrD;
    assign pcplus4D = r_pcplus4D;
    assign validD   = r_validD;
    assign ctrlE    = r_ctrlE;
    assign rd1E     = r_rd1E;
    assign rd2E     = r_rd2E;
    assign simmE    = r_simmE;
    assign rsE      = r_rsE;
    assign rtE      = r_rtE;
    assign rdE      = r_rdE;
    assign validE   = r_validE;

endmodule

`default_nettype wire
